// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between two producers.
// Never issues a write the FIFO would reject; keeps per-producer accept and stall counters.
module fifo_wr_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic [DATA_WIDTH-1:0] d0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] d1,
  input  logic [3:0]            fifo_data_count,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_d_in,
  output logic                  ack0,
  output logic                  ack1,
  output logic                  last_grant,
  output logic [CNT_WIDTH-1:0]  acc_cnt0,
  output logic [CNT_WIDTH-1:0]  acc_cnt1,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  typedef enum logic [1:0] {StIdle, StWrite, StStall} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] d_in_q, d_in_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic                  last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0]  acc0_q, acc0_d;
  logic [CNT_WIDTH-1:0]  acc1_q, acc1_d;
  logic [CNT_WIDTH-1:0]  stall_q, stall_d;

  logic [4:0] occ;
  logic       room;
  logic       elig0, elig1, grant1;

  assign fifo_wr_en = (state_q == StWrite);
  assign fifo_d_in  = d_in_q;
  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign last_grant = last_grant_q;
  assign acc_cnt0   = acc0_q;
  assign acc_cnt1   = acc1_q;
  assign stall_cnt  = stall_q;

  always_comb begin
    state_d      = StIdle;
    d_in_d       = d_in_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    last_grant_d = last_grant_q;
    acc0_d       = acc0_q;
    acc1_d       = acc1_q;
    stall_d      = stall_q;

    // The in-flight write is not yet in the FIFO's count, so add it in.
    occ  = {1'b0, fifo_data_count} + {4'b0000, fifo_wr_en};
    room = (occ < 5'(DEPTH));

    // A producer still showing req during its ack cycle already has its word taken.
    elig0  = req0 & ~ack0_q;
    elig1  = req1 & ~ack1_q;
    grant1 = elig1 & (~elig0 | ~last_grant_q);

    if (elig0 | elig1) begin
      if (!room) begin
        state_d = StStall;
        if (stall_q != '1) stall_d = stall_q + CNT_WIDTH'(1);
      end else begin
        state_d = StWrite;
        if (grant1) begin
          d_in_d       = d1;
          ack1_d       = 1'b1;
          last_grant_d = 1'b1;
          acc1_d       = acc1_q + CNT_WIDTH'(1);
        end else begin
          d_in_d       = d0;
          ack0_d       = 1'b1;
          last_grant_d = 1'b0;
          acc0_d       = acc0_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      d_in_q       <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      last_grant_q <= 1'b1;
      acc0_q       <= '0;
      acc1_q       <= '0;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      d_in_q       <= d_in_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      last_grant_q <= last_grant_d;
      acc0_q       <= acc0_d;
      acc1_q       <= acc1_d;
      stall_q      <= stall_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a behavioural 8-entry FIFO model on its write port.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [31:0] d0, d1;
  logic [3:0]  fifo_data_count;
  logic        fifo_wr_en;
  logic [31:0] fifo_d_in;
  logic        ack0, ack1, last_grant;
  logic [7:0]  acc_cnt0, acc_cnt1, stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  fifo_wr_arbiter #(
    .DATA_WIDTH(32),
    .DEPTH     (8),
    .CNT_WIDTH (8)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .req0           (req0),
    .d0             (d0),
    .req1           (req1),
    .d1             (d1),
    .fifo_data_count(fifo_data_count),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_d_in      (fifo_d_in),
    .ack0           (ack0),
    .ack1           (ack1),
    .last_grant     (last_grant),
    .acc_cnt0       (acc_cnt0),
    .acc_cnt1       (acc_cnt1),
    .stall_cnt      (stall_cnt)
  );

  always #5 clk = ~clk;

  // FIFO model: counts words, logs accepted writes, counts rejected writes (wr_err).
  logic        fifo_rst;
  logic        rd_en;
  int          fcnt = 0;
  int          wr_err_cnt = 0;
  logic [31:0] wr_log[$];
  bit          wok, rok;

  assign fifo_data_count = 4'(fcnt);

  always @(posedge clk) begin
    if (fifo_rst) begin
      fcnt <= 0;
    end else begin
      wok = fifo_wr_en && (fcnt < 8);
      rok = rd_en && (fcnt > 0);
      if (fifo_wr_en && !wok) wr_err_cnt <= wr_err_cnt + 1;
      if (wok) wr_log.push_back(fifo_d_in);
      fcnt <= fcnt + int'(wok) - int'(rok);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    int acks;

    reset    = 1'b1;
    fifo_rst = 1'b1;
    rd_en    = 1'b0;
    req0     = 1'b1;
    req1     = 1'b1;
    d0       = 32'h1111;
    d1       = 32'h2222;

    // Reset held two cycles with both producers requesting
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_wr_en", fifo_wr_en, 0);
      check("rst_ack0", ack0, 0);
      check("rst_ack1", ack1, 0);
    end
    check("rst_d_in", fifo_d_in, 0);
    check("rst_last_grant", last_grant, 1);
    check("rst_acc0", acc_cnt0, 0);
    check("rst_acc1", acc_cnt1, 0);
    check("rst_stall", stall_cnt, 0);
    reset    = 1'b0;
    fifo_rst = 1'b0;

    // Contention: strict alternation starting with producer 0, one word per cycle
    for (int i = 0; i < 8; i++) begin
      tick();
      check("cont_wr_en", fifo_wr_en, 1);
      check("cont_ack0", ack0, (i % 2 == 0) ? 1 : 0);
      check("cont_d_in", fifo_d_in, (i % 2 == 0) ? 32'h1111 : 32'h2222);
    end

    // Full: no more writes, stall counter climbs each cycle
    for (int j = 1; j <= 4; j++) begin
      tick();
      check("full_wr_en", fifo_wr_en, 0);
      check("full_stall_cnt", stall_cnt, j);
    end
    check("full_count", fcnt, 8);
    check("full_writes", wr_log.size(), 8);
    for (int i = 0; i < 8; i++)
      check("full_order", wr_log[i], (i % 2 == 0) ? 32'h1111 : 32'h2222);
    check("full_acc0", acc_cnt0, 4);
    check("full_acc1", acc_cnt1, 4);
    check("full_last_grant", last_grant, 1);
    check("full_wr_err", wr_err_cnt, 0);

    // Drain one word: exactly one more write, only once the count reads 7
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("drain_wait_wr_en", fifo_wr_en, 0);
    check("drain_count", fcnt, 7);
    tick();
    check("drain_wr_en", fifo_wr_en, 1);
    check("drain_ack0", ack0, 1);
    check("drain_d_in", fifo_d_in, 32'h1111);
    tick();
    check("drain_after_wr_en", fifo_wr_en, 0);
    check("drain_stall_cnt", stall_cnt, 6);
    tick();
    check("drain_after2_wr_en", fifo_wr_en, 0);
    check("drain_writes", wr_log.size(), 9);
    check("drain_wr_err", wr_err_cnt, 0);

    // Stall counter saturates
    repeat (260) tick();
    check("stall_sat", stall_cnt, 255);
    check("stall_sat_wr_err", wr_err_cnt, 0);

    // Single producer: one word every two cycles, incrementing data
    reset    = 1'b1;
    fifo_rst = 1'b1;
    req1     = 1'b0;
    d0       = 32'hA0;
    tick();
    reset    = 1'b0;
    fifo_rst = 1'b0;
    base     = wr_log.size();
    for (int i = 0; i < 6; i++) begin
      tick();
      check("single_ack0", ack0, (i % 2 == 0) ? 1 : 0);
      check("single_wr_en", fifo_wr_en, (i % 2 == 0) ? 1 : 0);
      check("single_d_in", fifo_d_in, 32'hA0 + 32'(i / 2));
      if (ack0) d0 = d0 + 32'd1;
    end
    check("single_writes", wr_log.size() - base, 3);
    for (int k = 0; k < 3; k++)
      check("single_order", wr_log[base + k], 32'hA0 + 32'(k));

    // Reset with a grant pending: the write is dropped
    reset = 1'b1;
    tick();
    check("rst_mid_wr_en", fifo_wr_en, 0);
    check("rst_mid_ack0", ack0, 0);

    // Counter wrap: one word from producer 0, then 256 from producer 1
    fifo_rst = 1'b1;
    tick();
    fifo_rst = 1'b0;
    reset    = 1'b0;
    rd_en    = 1'b1;
    tick();
    check("wrap_ack0", ack0, 1);
    check("wrap_acc0_pre", acc_cnt0, 1);
    req0 = 1'b0;
    req1 = 1'b1;
    d1   = 32'h0;
    acks = 0;
    for (int c = 0; c < 600 && acks < 256; c++) begin
      tick();
      if (ack1) begin
        acks++;
        d1 = d1 + 32'd1;
        if (acks == 255) check("wrap_acc1_255", acc_cnt1, 255);
      end
    end
    req1 = 1'b0;
    check("wrap_acks", acks, 256);
    check("wrap_acc1", acc_cnt1, 0);
    check("wrap_acc0", acc_cnt0, 1);
    check("wrap_wr_err", wr_err_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
